// File: rtl/sprot_seq_ctrl.sv
// sprot_seq_ctrl
//   Master-side sequencer for the sprot bus. Picks one of NUM_REQ requesters
//   round-robin, drives the start -> a -> b strobe sequence, waits for the
//   slave to finish or flag an error, retries failed attempts up to MAX_RETRY
//   times and reports done/fail back to the granted requester.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-requester level request
//   gnt       : one-hot grant, held across retries and through the done/fail cycle
//   done      : one-cycle success pulse to the granted requester
//   fail      : one-cycle pulse when all retries are exhausted
//   start/a/b : sprot strobes, one cycle each on consecutive cycles
//   prot_err  : slave protocol error
//   xfer_end  : slave transfer complete
//   busy      : high whenever the sequencer is not idle
//   err_cnt   : saturating count of failed attempts
module sprot_seq_ctrl #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] fail,
    output logic               start,
    output logic               a,
    output logic               b,
    input  logic               prot_err,
    input  logic               xfer_end,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_PH_A, S_PH_B, S_WAIT, S_GAP
    } state_t;

    state_t             state, state_n;
    logic [PW-1:0]      rr_ptr, rr_ptr_n;
    logic [PW-1:0]      idx, idx_n;
    logic [2:0]         retry_cnt, retry_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [7:0]         err_n;
    logic [NUM_REQ-1:0] gnt_n, done_n, fail_n;
    logic               winner_found;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      ptr_after_idx;
    logic               ok_ev, err_ev;

    // Round-robin search: first set request at or after rr_ptr, wrapping.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!winner_found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                winner_found = 1'b1;
                winner       = PW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign ptr_after_idx = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        idx_n    = idx;
        rr_ptr_n = rr_ptr;
        retry_n  = retry_cnt;
        tcnt_n   = tcnt;
        err_n    = err_cnt;
        done_n   = '0;
        fail_n   = '0;
        ok_ev    = 1'b0;
        err_ev   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (winner_found) begin
                    idx_n   = winner;
                    gnt_n   = NUM_REQ'(1) << winner;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (prot_err) err_ev = 1'b1;
                else          state_n = S_PH_A;
            end
            S_PH_A: begin
                if (prot_err) err_ev = 1'b1;
                else          state_n = S_PH_B;
            end
            S_PH_B: begin
                if (prot_err) begin
                    err_ev = 1'b1;
                end else begin
                    state_n = S_WAIT;
                    tcnt_n  = '0;
                end
            end
            S_WAIT: begin
                // Error wins over a simultaneous xfer_end.
                if (prot_err)                       err_ev = 1'b1;
                else if (xfer_end)                  ok_ev  = 1'b1;
                else if (tcnt == TW'(TIMEOUT - 1))  err_ev = 1'b1;
                else                                tcnt_n = tcnt + 1'b1;
            end
            S_GAP: begin
                // gnt stays up through the done/fail cycle and drops here.
                gnt_n   = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (ok_ev) begin
            done_n   = gnt;
            retry_n  = '0;
            rr_ptr_n = ptr_after_idx;
            state_n  = S_GAP;
        end

        if (err_ev) begin
            err_n = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            if (int'(retry_cnt) < MAX_RETRY) begin
                retry_n = retry_cnt + 3'd1;
                state_n = S_START;
            end else begin
                fail_n   = gnt;
                retry_n  = '0;
                rr_ptr_n = ptr_after_idx;
                state_n  = S_GAP;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt       <= '0;
            idx       <= '0;
            rr_ptr    <= '0;
            retry_cnt <= '0;
            tcnt      <= '0;
            err_cnt   <= '0;
            done      <= '0;
            fail      <= '0;
            start     <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            idx       <= idx_n;
            rr_ptr    <= rr_ptr_n;
            retry_cnt <= retry_n;
            tcnt      <= tcnt_n;
            err_cnt   <= err_n;
            done      <= done_n;
            fail      <= fail_n;
            // Strobes are decoded from the next state so they come straight
            // out of flops, aligned with the state they belong to.
            start     <= (state_n == S_START);
            a         <= (state_n == S_PH_A);
            b         <= (state_n == S_PH_B);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_sprot_seq_ctrl.sv
// Self-checking bench for sprot_seq_ctrl with default parameters
// (NUM_REQ=4, TIMEOUT=16, MAX_RETRY=2). Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point.
module tb_sprot_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt, done, fail;
    logic       start, a, b, busy;
    logic       prot_err = 1'b0;
    logic       xfer_end = 1'b0;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    sprot_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .done     (done),
        .fail     (fail),
        .start    (start),
        .a        (a),
        .b        (b),
        .prot_err (prot_err),
        .xfer_end (xfer_end),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; prot_err = 1'b0; xfer_end = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Steps until start is seen; found=0 if it never comes.
    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // From a start cycle: PH_A, PH_B, first WAIT cycle.
    task automatic to_wait();
        step(); step(); step();
    endtask

    // From a start cycle: run to success and land in the following IDLE cycle.
    task automatic finish_xfer();
        to_wait();
        xfer_end = 1'b1;
        step();
        xfer_end = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({gnt, done, fail, start, a, b, busy, err_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b done=%b fail=%b s/a/b/busy=%b%b%b%b err_cnt=%0d, want all 0",
                     gnt, done, fail, start, a, b, busy, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        checks++;
        if ({busy, gnt, start} !== 6'b0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b gnt=%b start=%b, want 0/0000/0", busy, gnt, start);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;  // dropping req must not abort
        checks++;
        if ({gnt, start, a, b, busy} !== {4'b0001, 4'b1001}) begin
            errors++;
            $display("FAIL single_T1: got gnt=%b s/a/b/busy=%b%b%b%b, want 0001 1001", gnt, start, a, b, busy);
        end
        step();
        checks++;
        if ({start, a, b} !== 3'b010) begin
            errors++;
            $display("FAIL single_T2: got s/a/b=%b%b%b, want 010", start, a, b);
        end
        step();
        checks++;
        if ({start, a, b} !== 3'b001) begin
            errors++;
            $display("FAIL single_T3: got s/a/b=%b%b%b, want 001", start, a, b);
        end
        step();  // first WAIT cycle
        checks++;
        if ({start, a, b, busy, gnt} !== {4'b0001, 4'b0001}) begin
            errors++;
            $display("FAIL single_wait: got s/a/b/busy=%b%b%b%b gnt=%b, want 0001 0001", start, a, b, busy, gnt);
        end
        step();  // second WAIT cycle
        xfer_end = 1'b1;
        step();
        xfer_end = 1'b0;
        checks++;
        if ({done, gnt, fail} !== {4'b0001, 4'b0001, 4'b0000}) begin
            errors++;
            $display("FAIL single_done: got done=%b gnt=%b fail=%b, want 0001 0001 0000", done, gnt, fail);
        end
        step();
        checks++;
        if ({done, gnt, busy, err_cnt} !== {4'b0, 4'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL single_after: got done=%b gnt=%b busy=%b err_cnt=%0d, want 0000 0000 0 0",
                     done, gnt, busy, err_cnt);
        end
    endtask

    task automatic test_round_robin();
        bit found;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            wait_start(found);
            checks++;
            if (!found || gnt !== exp_gnt) begin
                errors++;
                $display("FAIL rr_grant_%0d: got start_seen=%0d gnt=%b, want 1 %b", k, found, gnt, exp_gnt);
            end
            to_wait();
            xfer_end = 1'b1;
            step();
            xfer_end = 1'b0;
            checks++;
            if (done !== exp_gnt) begin
                errors++;
                $display("FAIL rr_done_%0d: got done=%b, want %b", k, done, exp_gnt);
            end
            step();
            checks++;
            if ({gnt, start} !== 5'b0) begin
                errors++;
                $display("FAIL rr_gap_%0d: got gnt=%b start=%b, want 0000 0", k, gnt, start);
            end
        end
        req = '0;
    endtask

    task automatic test_retry_success();
        bit found;
        int starts = 0;
        do_reset();
        req = 4'b0010;
        wait_start(found);
        req = '0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL retry_first_start: got no start, want start");
        end
        for (int att = 1; att <= 3; att++) begin
            if (start === 1'b1 && gnt === 4'b0010) starts++;
            to_wait();
            if (att < 3) prot_err = 1'b1;
            else         xfer_end = 1'b1;
            step();
            prot_err = 1'b0;
            xfer_end = 1'b0;
            if (att < 3) begin
                checks++;
                if ({start, fail, done} !== {1'b1, 8'b0}) begin
                    errors++;
                    $display("FAIL retry_restart_%0d: got start=%b fail=%b done=%b, want 1 0000 0000",
                             att, start, fail, done);
                end
            end
        end
        checks++;
        if ({done, fail, err_cnt} !== {4'b0010, 4'b0000, 8'd2} || starts != 3) begin
            errors++;
            $display("FAIL retry_result: got done=%b fail=%b err_cnt=%0d starts=%0d, want 0010 0000 2 3",
                     done, fail, err_cnt, starts);
        end
    endtask

    task automatic test_timeout_exhaust();
        bit found;
        do_reset();
        req = 4'b0100;
        wait_start(found);
        req = '0;
        for (int att = 1; att <= 3; att++) begin
            to_wait();          // WAIT cycle 1 (T+4)
            repeat (15) step(); // WAIT cycle 16 (T+19)
            checks++;
            if ({start, busy, fail} !== {2'b01, 4'b0}) begin
                errors++;
                $display("FAIL timeout_early_%0d: got start=%b busy=%b fail=%b, want 0 1 0000",
                         att, start, busy, fail);
            end
            step();             // T+20
            if (att < 3) begin
                checks++;
                if ({start, gnt, err_cnt} !== {1'b1, 4'b0100, 8'(att)}) begin
                    errors++;
                    $display("FAIL timeout_retry_%0d: got start=%b gnt=%b err_cnt=%0d, want 1 0100 %0d",
                             att, start, gnt, err_cnt, att);
                end
            end else begin
                checks++;
                if ({fail, done, start, err_cnt} !== {4'b0100, 4'b0, 1'b0, 8'd3}) begin
                    errors++;
                    $display("FAIL timeout_fail: got fail=%b done=%b start=%b err_cnt=%0d, want 0100 0000 0 3",
                             fail, done, start, err_cnt);
                end
            end
        end
        step();
        checks++;
        if ({fail, gnt, busy} !== 9'b0) begin
            errors++;
            $display("FAIL timeout_after: got fail=%b gnt=%b busy=%b, want 0000 0000 0", fail, gnt, busy);
        end
    endtask

    task automatic test_corners();
        bit found;
        do_reset();
        req = 4'b0001;
        wait_start(found);
        req = '0;
        to_wait();
        prot_err = 1'b1;
        xfer_end = 1'b1;
        step();
        prot_err = 1'b0;
        xfer_end = 1'b0;
        checks++;
        if ({start, done, err_cnt} !== {1'b1, 4'b0, 8'd1}) begin
            errors++;
            $display("FAIL both_err_end: got start=%b done=%b err_cnt=%0d, want 1 0000 1", start, done, err_cnt);
        end
        step();  // PH_A
        prot_err = 1'b1;
        step();
        prot_err = 1'b0;
        checks++;
        if ({start, a, err_cnt} !== {2'b10, 8'd2}) begin
            errors++;
            $display("FAIL pha_err_retry: got start=%b a=%b err_cnt=%0d, want 1 0 2", start, a, err_cnt);
        end
        to_wait();
        xfer_end = 1'b1;
        step();
        xfer_end = 1'b0;
        checks++;
        if ({done, fail, err_cnt} !== {4'b0001, 4'b0, 8'd2}) begin
            errors++;
            $display("FAIL corner_done: got done=%b fail=%b err_cnt=%0d, want 0001 0000 2", done, fail, err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req = 4'b1111;
        prot_err = 1'b1;  // every START cycle is an error: 3 errors per 5 cycles
        repeat (600) step();
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_cnt_sat: got err_cnt=%0d, want 255", err_cnt);
        end
        prot_err = 1'b0;
        req = '0;
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        req = 4'b0100;       // leaves rr_ptr at 3
        wait_start(found);
        req = '0;
        finish_xfer();
        req = 4'b1000;
        wait_start(found);
        req = '0;
        checks++;
        if (!found || gnt !== 4'b1000) begin
            errors++;
            $display("FAIL pre_reset_grant: got start_seen=%0d gnt=%b, want 1 1000", found, gnt);
        end
        step(); step();      // PH_B
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, fail, start, a, b, busy, err_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b done=%b fail=%b s/a/b/busy=%b%b%b%b err_cnt=%0d, want all 0",
                     gnt, done, fail, start, a, b, busy, err_cnt);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;       // rr_ptr back at 0 -> requester 0 wins
        wait_start(found);
        req = '0;
        checks++;
        if (!found || gnt !== 4'b0001 || fail !== 4'b0) begin
            errors++;
            $display("FAIL rr_restart: got start_seen=%0d gnt=%b fail=%b, want 1 0001 0000", found, gnt, fail);
        end
        finish_xfer();
        req = 4'b0100;
        wait_start(found);
        req = '0;
        checks++;
        if (!found || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_grant: got start_seen=%0d gnt=%b, want 1 0100", found, gnt);
        end
        finish_xfer();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_retry_success();
        test_timeout_exhaust();
        test_corners();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
